// File: rtl/borrow_select_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module  : borrow_select_subtractor_seq
// Brief   : Multi-cycle borrow-select subtractor, DIFF = x - y - Bin, one
//           K-bit chunk per clock, LSB chunk first, valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module borrow_select_subtractor_seq #(
    parameter int N = 15,
    parameter int K = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [N:0] x,
    input  logic [N:0] y,
    input  logic       Bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [N:0] DIFF,
    output logic       Bout,
    output logic       V
);

    localparam int C    = (N + 1) / K;
    localparam int IDXW = (C > 1) ? $clog2(C) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(C - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N:0]      x_q, x_d;
    logic [N:0]      y_q, y_d;
    logic            borrow_q, borrow_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N:0]      acc_q, acc_d;
    logic [N:0]      diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            v_q, v_d;

    logic [31:0]     w_base;
    logic [K-1:0]    w_xi;
    logic [K-1:0]    w_yi;
    logic [K:0]      w_sub0;
    logic [K:0]      w_sub1;
    logic [K:0]      w_sel;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        v_d      = v_q;

        w_base = 32'(idx_q) * K;
        w_xi   = x_q[w_base +: K];
        w_yi   = y_q[w_base +: K];
        // Both borrow-in cases precomputed; the MSB of each K+1 bit result is its borrow.
        w_sub0 = {1'b0, w_xi} - {1'b0, w_yi};
        w_sub1 = w_sub0 - (K + 1)'(1);
        w_sel  = borrow_q ? w_sub1 : w_sub0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = x;
                    y_d      = y;
                    borrow_d = Bin;
                    idx_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d[w_base +: K] = w_sel[K-1:0];
                borrow_d           = w_sel[K];
                idx_d              = idx_q + IDXW'(1);
                if (idx_q == C_LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    diff_d  = acc_d;
                    bout_d  = w_sel[K];
                    v_d     = (x_q[N] ^ y_q[N]) & (acc_d[N] ^ x_q[N]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign DIFF      = diff_q;
    assign Bout      = bout_q;
    assign V         = v_q;

endmodule
`default_nettype wire

// File: doc/borrow_select_subtractor_seq.md
Name: borrow_select_subtractor_seq

Overview:
Multi-cycle unsigned/two's-complement subtractor computing DIFF = x - y - Bin. It processes the operand in K-bit chunks, one chunk per clock, LSB chunk first. For each chunk it precomputes both borrow-in cases (borrow=0 and borrow=1) and selects one using the registered running borrow. This is the borrow-select counterpart of the team's carry-select adder. It is used in the arithmetic datapath wherever wide subtraction must meet timing, with valid/ready handshakes on both sides.

Parameters:
N, 15, MSB index of the operands; operand width is N+1 (same [N:0] convention as the adder).
K, 4, chunk width in bits. (N+1) must be an exact multiple of K. The number of chunks is C = (N+1)/K.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  reset, asynchronous and active-low.
in_valid  input  1  operands present on x, y, Bin.
in_ready  output  1  block can accept operands.
x  input  [N:0]  minuend.
y  input  [N:0]  subtrahend.
Bin  input  1  borrow in.
out_valid  output  1  DIFF, Bout and V are valid.
out_ready  input  1  downstream accepts the result.
DIFF  output  [N:0]  x - y - Bin, modulo 2^(N+1).
Bout  output  1  borrow out; 1 iff x < y + Bin, compared as unsigned.
V  output  1  signed overflow of the subtraction (two's-complement interpretation).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - DIFF=0, Bout=0, V=0, out_valid=0, in_ready=1.
  - Chunk counter and borrow register are cleared.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in IDLE with in_valid=1 on a rising edge:
  - x, y and Bin are captured into internal registers.
  - Borrow register is loaded with Bin, chunk index is set to 0, FSM goes to BUSY.
  - Changes on x, y or Bin after the accept edge have no effect.
- BUSY, each cycle, for chunk i (bits i*K+K-1 .. i*K):
  - d0 = xi - yi and d1 = xi - yi - 1, each with its own K-bit result and borrow.
  - The registered borrow selects d0/b0 (borrow=0) or d1/b1 (borrow=1).
  - The selected K bits are written into the DIFF accumulation register; the borrow register takes the selected borrow.
  - The index increments.
  - After chunk C-1, the FSM goes to DONE. Bout is the final borrow. V = (x[N] xor y[N]) and (DIFF[N] xor x[N]).
- Latency: out_valid rises exactly C cycles after the accept edge (4 cycles at the defaults). DIFF, Bout and V update in the same cycle out_valid rises.
- DONE:
  - Outputs are held stable while out_ready=0.
  - With out_ready=1, the result is consumed and the FSM returns to IDLE. in_ready is 1 on the next cycle.
  - No back-to-back overlap: throughput is one result per C+2 cycles.
- DIFF, Bout and V keep their last values in IDLE and BUSY. Only out_valid qualifies them.
- in_valid while in BUSY or DONE is ignored; no queueing.
- K = N+1 (C=1) is legal: the result is ready one cycle after accept.
- Reset mid-operation (BUSY or DONE) aborts the operation. The partial result is discarded and all outputs take their reset values.

Test Plan:
1. N=15, K=4, x=0x1234, y=0x0234, Bin=0 -> 4 cycles after accept: out_valid=1, DIFF=0x1000, Bout=0, V=0.
2. x=0x0000, y=0x0001, Bin=0 -> DIFF=0xFFFF, Bout=1, V=0. Separately, x=0x0000, y=0x0000, Bin=1 -> DIFF=0xFFFF, Bout=1, V=0. Both exercise the borrow ripple through all chunks.
3. x=0x8000, y=0x0001, Bin=0 -> DIFF=0x7FFF, Bout=0, V=1. Also x=0x7FFF, y=0xFFFF, Bin=0 -> DIFF=0x8000, Bout=1, V=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid rises, and pulse in_valid with new operands during that time -> DIFF, Bout and V stay stable, in_ready=0, and the new operands are not captured. When out_ready=1, the FSM goes to IDLE and in_ready=1 on the next cycle.
5. Reset mid-operation: assert rst_n=0 two cycles after accept -> out_valid=0, DIFF=0, Bout=0, V=0 immediately (asynchronously). After release, in_ready=1 and a fresh subtraction (0x0005 - 0x0003 -> 0x0002) completes correctly.
6. Random: 1000 operand sets for both K=4 and K=16, checked against a reference x-y-Bin with full-width borrow and overflow -> no mismatches, and latency equals C in every case.
